mdu_iter: RTL and testbench
===========================

// Module: mdu_iter
// PURPOSE
//  Iterative multiply/divide unit for the EX stage, beside the single-cycle ALU (RV32M ops).
//  Hazard unit stalls the pipe while busy=1. Result C is muxed into the EX/MEM result when done=1.
//  Ops are selected by funct3.
// PARAMETERS
//  XLEN             32  operand/result width
//  STEPS_PER_CYCLE  1   radix-2 iterations per CALC cycle; must divide XLEN (1,2,4)
// PORTS
//  clk     in   1     clock, rising edge
//  rstn    in   1     asynchronous active-low reset
//  start   in   1     request; sampled only in IDLE
//  op      in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  A       in   XLEN  rs1 operand (dividend / multiplicand)
//  B       in   XLEN  rs2 operand (divisor / multiplier)
//  flush   in   1     kill in-flight op (branch/exception flush)
//  busy    out  1     1 from the cycle after start accepted until done
//  done    out  1     one-cycle pulse; C valid
//  C       out  XLEN  result; holds until next accepted start
//  illegal out  1     with done: op not supported in this build
// BEHAVIOUR
//  Reset (rstn=0, async): state=IDLE, busy=0, done=0, illegal=0, C=0, all internal regs 0.
//  FSM IDLE->CALC->FIX->DONE->IDLE.
//  IDLE: start=1 & flush=0 latches op, |A|, |B| and result sign flags, and clears the counter.
//    Next state is CALC, or DONE for a special case.
//  CALC: XLEN/STEPS_PER_CYCLE cycles; counter increments by STEPS_PER_CYCLE; at XLEN -> FIX.
//  FIX: apply sign correction, register C -> DONE.
//  DONE: done=1, busy=0 for exactly one cycle -> IDLE. A new start is accepted only in IDLE.
//  Latency, start cycle to done cycle: XLEN/STEPS_PER_CYCLE+2 (34 at defaults).
//  Divide: restoring, unsigned magnitudes. Quotient sign = sA^sB; remainder sign = sA.
//    sA/sB are operand MSBs for DIV/REM; 0 for DIVU/REMU.
//  Divide special cases go directly IDLE->DONE (done the cycle after start):
//    B==0: DIV/DIVU C=32'hFFFF_FFFF; REM/REMU C=A.
//    DIV  A=32'h8000_0000, B=-1: C=32'h8000_0000.
//    REM  A=32'h8000_0000, B=-1: C=0.
//  Multiply: shift-add over a 2*XLEN accumulator.
//    MUL = low half; MULH/MULHSU/MULHU = high half.
//    Signedness: MULH s*s, MULHSU s*u, MULHU u*u. Negate the 64-bit product when sign set.
//  Arithmetic is width-exact: magnitude of -2^31 is 2^31 (unsigned XLEN), with no overflow.
//  flush=1 in any state: next edge -> IDLE, busy=0, done not asserted, C unchanged.
//  flush and start in the same cycle: flush wins, start is dropped.
//  start while busy: ignored; operands are not re-latched.
//  A/B/op may change freely after the start cycle.
// CONFIGURATION
//  MDU_MUL_EN defined: all eight ops implemented as above.
//  MDU_MUL_EN undefined: multiply datapath removed.
//    op[2]=0 goes IDLE->DONE with C=0, illegal=1 (done the cycle after start).
//    Divide ops are unchanged.
// STRUCTURE
//  Shared header mdu_def.v (`include, as ctrl_encode_def.v) holds:
//    MDU_OP_* funct3 codes, MDU_ST_* state encodings (2-bit), XLEN default.
//  Sub-module mdu_div_step: combinational single restoring step (rem,quot,divisor -> rem',quot').
//    Instantiated STEPS_PER_CYCLE times in a generate chain.
//  Multiply reuses the latched operand regs and the shared accumulator; no separate module.
// TESTING
//  DIV A=-7 B=2 -> done at start+34, C=-3 (FFFF_FFFD); REM same operands -> C=-1.
//  DIVU A=100 B=0 -> done at start+1, C=FFFF_FFFF; REMU A=100 B=0 -> C=100.
//  DIV A=8000_0000 B=FFFF_FFFF -> start+1, C=8000_0000; REM -> C=0; busy never high.
//  MULH A=8000_0000 B=8000_0000 -> C=4000_0000; MULHSU A=-1 B=FFFF_FFFF -> C=FFFF_FFFF;
//    MUL A=3 B=-5 -> C=FFFF_FFF1. Without MDU_MUL_EN: illegal=1, C=0.
//  Flush at CALC cycle 10, then start DIVU 100/7 the next IDLE cycle -> no done for the
//    first op; C=14 at +34.
//  Start pulsed during busy, and start+flush together -> ignored/dropped; assert rstn low
//    mid-CALC -> busy=0, done=0, C=0 immediately.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared width default, funct3 codes and FSM encoding for the iterative multiply/divide unit
package mdu_pkg;
  localparam int MDU_XLEN = 32;
  localparam logic [2:0] MDU_OP_DIV = 3'b100;
  localparam logic [2:0] MDU_OP_REM = 3'b110;
  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_CALC = 2'd1,
    MDU_ST_FIX  = 2'd2,
    MDU_ST_DONE = 2'd3
  } mdu_state_t;
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one combinational restoring-division step on unsigned magnitudes
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);
  logic [XLEN:0] sh;
  logic ge;
  assign sh = {rem, quot[XLEN-1]};
  assign ge = sh >= {1'b0, divisor};
  // the difference is below divisor whenever ge, so XLEN bits hold it exactly
  assign rem_o = ge ? sh[XLEN-1:0] - divisor : sh[XLEN-1:0];
  assign quot_o = {quot[XLEN-2:0], ge};
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit for the EX stage.
// Multiply ops are built only when MDU_MUL_EN is defined; otherwise they finish at once flagged illegal.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] C,
  output logic            illegal
);
  localparam int CW = $clog2(XLEN) + 1;
  mdu_state_t state, state_n;
  logic div_q, sel_q, neg_q, ill_q;
  logic [XLEN-1:0] mb;
  logic [2*XLEN-1:0] acc, acc_n;
  logic [CW-1:0] cnt;
  logic signed_a, signed_b, sa, sb, div0, ovf, special, accept, last;
  logic [XLEN-1:0] ma_in, mb_in, spec_c, div_res, div_fix, res;
  logic [XLEN-1:0] rem_c [STEPS_PER_CYCLE+1];
  logic [XLEN-1:0] quot_c [STEPS_PER_CYCLE+1];
  assign signed_a = op[2] ? ~op[0] : ~(op[1] & op[0]);
  assign signed_b = op[2] ? ~op[0] : ~op[1];
  assign sa = signed_a & A[XLEN-1];
  assign sb = signed_b & B[XLEN-1];
  assign ma_in = sa ? -A : A;
  assign mb_in = sb ? -B : B;
  assign div0 = op[2] && B == '0;
  assign ovf = (op == MDU_OP_DIV || op == MDU_OP_REM) && A == {1'b1, {(XLEN-1){1'b0}}} && B == '1;
`ifdef MDU_MUL_EN
  assign special = div0 | ovf;
`else
  assign special = div0 | ovf | ~op[2];
`endif
  assign spec_c = !op[2] ? '0 : div0 ? (op[1] ? A : '1) : (op[1] ? '0 : A);
  assign accept = state == MDU_ST_IDLE && start && !flush;
  assign last = cnt == CW'(XLEN - STEPS_PER_CYCLE);
  assign busy = state == MDU_ST_CALC || state == MDU_ST_FIX;
  assign done = state == MDU_ST_DONE;
  assign illegal = done & ill_q;
  always_comb begin
    state_n = state;
    case (state)
      MDU_ST_IDLE: state_n = accept ? (special ? MDU_ST_DONE : MDU_ST_CALC) : MDU_ST_IDLE;
      MDU_ST_CALC: state_n = last ? MDU_ST_FIX : MDU_ST_CALC;
      MDU_ST_FIX:  state_n = MDU_ST_DONE;
      default:     state_n = MDU_ST_IDLE;
    endcase
    if (flush) state_n = MDU_ST_IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= MDU_ST_IDLE;
    else state <= state_n;
  // acc holds {remainder, quotient} for divide and the running product for multiply
  assign rem_c[0] = acc[2*XLEN-1:XLEN];
  assign quot_c[0] = acc[XLEN-1:0];
  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_div
    mdu_div_step #(.XLEN(XLEN)) u_step (
      .rem(rem_c[g]),
      .quot(quot_c[g]),
      .divisor(mb),
      .rem_o(rem_c[g+1]),
      .quot_o(quot_c[g+1])
    );
  end
  assign div_res = sel_q ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  assign div_fix = neg_q ? -div_res : div_res;
`ifdef MDU_MUL_EN
  logic [2*XLEN-1:0] mul_acc, prod;
  logic [XLEN:0] sum;
  always_comb begin
    mul_acc = acc;
    sum = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      sum = {1'b0, mul_acc[2*XLEN-1:XLEN]} + (mul_acc[0] ? {1'b0, mb} : '0);
      mul_acc = {sum, mul_acc[XLEN-1:1]};
    end
  end
  assign acc_n = div_q ? {rem_c[STEPS_PER_CYCLE], quot_c[STEPS_PER_CYCLE]} : mul_acc;
  assign prod = neg_q ? -acc : acc;
  assign res = div_q ? div_fix : sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
`else
  assign acc_n = {rem_c[STEPS_PER_CYCLE], quot_c[STEPS_PER_CYCLE]};
  assign res = div_q ? div_fix : '0;
`endif
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      div_q <= 1'b0;
      sel_q <= 1'b0;
      neg_q <= 1'b0;
      ill_q <= 1'b0;
      mb <= '0;
      acc <= '0;
      cnt <= '0;
      C <= '0;
    end else if (accept) begin
      div_q <= op[2];
      sel_q <= op[2] ? op[1] : |op[1:0];
      neg_q <= op[2] && op[1] ? sa : sa ^ sb;
      ill_q <= special & ~op[2];
      mb <= mb_in;
      acc <= {{XLEN{1'b0}}, ma_in};
      cnt <= '0;
      if (special) C <= spec_c;
    end else if (state == MDU_ST_CALC) begin
      acc <= acc_n;
      cnt <= cnt + CW'(STEPS_PER_CYCLE);
    end else if (state == MDU_ST_FIX && !flush) begin
      C <= res;
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed scoreboard bench for mdu_iter (default or MDU_MUL_EN build)
module tb_mdu_iter;
  localparam int LAT = 34;
`ifdef MDU_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif
  typedef struct {
    logic [31:0] c;
    logic ill;
    int lat;
  } exp_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic busy, done, illegal;
  logic [31:0] C;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_c = '0;
  logic [31:0] ua, ub;
  logic signed [31:0] sa_v, sb_v;
  always #5 clk = ~clk;
  mdu_iter dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .op(op),
    .A(A),
    .B(B),
    .flush(flush),
    .busy(busy),
    .done(done),
    .C(C),
    .illegal(illegal)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // called at a negedge with the unit idle; returns at the negedge after done
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c, input logic ill, input int lat, input bit poke);
    exp_t e;
    int n;
    bit seen_busy;
    sb.push_back('{c: c, ill: ill, lat: lat});
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
    n = 1;
    seen_busy = 1'b0;
    while (!done && n < 200) begin
      seen_busy |= busy;
      start = poke && n == 5;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check($sformatf("latency op%0d", o), done ? 32'(n) : 32'd0, 32'(e.lat));
    check($sformatf("C op%0d", o), C, e.c);
    check($sformatf("illegal op%0d", o), 32'(illegal), 32'(e.ill));
    check($sformatf("busy_seen op%0d", o), 32'(seen_busy), 32'(e.lat > 1));
    last_c = e.c;
    @(negedge clk);
  endtask
  initial begin
    #2;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset C", C, 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, LAT, 1'b0);
    run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, LAT, 1'b0);
    run(3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, 1'b0);
    run(3'b111, 32'd100, 32'd0, 32'd100, 1'b0, 1, 1'b0);
    run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 1'b0);
    run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1, 1'b0);
    run(3'b001, 32'h8000_0000, 32'h8000_0000, MUL ? 32'h4000_0000 : 32'd0, !MUL, MUL ? LAT : 1, 1'b0);
    run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL ? 32'hFFFF_FFFF : 32'd0, !MUL, MUL ? LAT : 1, 1'b0);
    run(3'b000, 32'd3, 32'hFFFF_FFFB, MUL ? 32'hFFFF_FFF1 : 32'd0, !MUL, MUL ? LAT : 1, 1'b0);
    run(3'b011, 32'hFFFF_FFFF, 32'd2, MUL ? 32'd1 : 32'd0, !MUL, MUL ? LAT : 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ua = $urandom;
      ub = $urandom_range(5000, 1);
      run(3'b101, ua, ub, ua / ub, 1'b0, LAT, 1'b0);
      run(3'b111, ua, ub, ua % ub, 1'b0, LAT, 1'b0);
      sa_v = $urandom;
      sb_v = $urandom_range(200, 2);
      if ($urandom_range(1, 0) == 1) sb_v = -sb_v;
      run(3'b100, sa_v, sb_v, sa_v / sb_v, 1'b0, LAT, 1'b0);
      run(3'b110, sa_v, sb_v, sa_v % sb_v, 1'b0, LAT, 1'b0);
    end
    // a start pulse while busy must neither restart nor re-latch operands
    run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, LAT, 1'b1);
    start = 1'b1; op = 3'b101; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    check("flush C", C, last_c);
    run(3'b101, 32'd100, 32'd7, 32'd14, 1'b0, LAT, 1'b0);
    start = 1'b1; flush = 1'b1; op = 3'b101; A = 32'd9; B = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start+flush busy", 32'(busy), 32'd0);
    check("start+flush done", 32'(done), 32'd0);
    @(negedge clk);
    check("start+flush done later", 32'(done), 32'd0);
    check("start+flush C", C, last_c);
    start = 1'b1; op = 3'b100; A = 32'hFFFF_FFF9; B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset C", C, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run(3'b101, 32'd100, 32'd7, 32'd14, 1'b0, LAT, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
